approx_div_32x16: RTL and testbench
===================================

Name: approx_div_32x16

Overview:
- Iterative restoring divider: 32-bit dividend / 16-bit divisor -> 16-bit quotient, 16-bit remainder.
- It is the inverse-direction companion to the approximate multiplier datapath, used to undo or normalise products in the same accuracy-configurable pipeline.
- precise_en selects between two modes:
  - exact: DW iterations;
  - approximate: only the first APPROX_ITERS iterations, which trades latency for accuracy.
- Valid/ready handshake on both input and output sides.

Parameters:
- DW, 16: divisor, quotient and remainder width. Dividend width is 2*DW.
- APPROX_ITERS, 8: iterations run in approximate mode. Legal range 1..DW. An illegal value is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept. Combinational decode of state IDLE.
- dividend  input  2*DW  numerator, unsigned.
- divisor  input  DW  denominator, unsigned.
- precise_en  input  1  1 = exact; 0 = approximate. Sampled only at accept.
- out_valid  output  1  result valid. Registered.
- out_ready  input  1  consumer accepts result.
- quotient  output  DW  result quotient. Registered.
- remainder  output  DW  result remainder. Registered.
- div_by_zero  output  1  divisor was 0. Registered.
- overflow  output  1  quotient does not fit in DW bits. Registered.
- out_precise  output  1  echo of the precise_en value sampled for this result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0; quotient = remainder = 0; div_by_zero = overflow = out_precise = 0.
  - in_ready reads 1, because state is IDLE.
  - Reset mid-operation abandons the operation silently. No result is ever emitted for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch dividend, divisor and precise_en.
  - Load iteration counter = DW if precise_en else APPROX_ITERS. Clear partial remainder/quotient.
  - Next state:
    - divisor == 0: DONE with div_by_zero = 1, overflow = 0, quotient = all-ones, remainder = 0.
    - else dividend[2DW-1:DW] >= divisor: DONE with overflow = 1, quotient = all-ones, remainder = 0.
    - else CALC.
  - For both special cases, out_valid rises 1 cycle after the accept edge.
- CALC:
  - One restoring step per cycle, MSB first.
  - Shift the (DW+1)-bit partial remainder left, bringing in the next dividend bit.
  - Trial-subtract divisor. If non-negative: keep the difference and shift in quotient bit 1; else shift in 0.
  - Decrement counter. On the step where it reaches 0: go to DONE, register results, out_valid = 1.
- Latency (accept edge to out_valid high): DW cycles precise, APPROX_ITERS cycles approximate.
- Precise result: exact floor quotient and remainder.
- Approximate result:
  - quotient = exact quotient with its low (DW-APPROX_ITERS) bits forced to 0. The restoring prefix is exact.
  - remainder = 0.
  - If APPROX_ITERS == DW, the result equals precise mode.
- DONE:
  - out_valid = 1; all outputs held stable; in_ready = 0; in_valid is ignored.
  - On out_valid & out_ready: go to IDLE and clear out_valid. Result registers hold their last value.
  - No accept is possible in the same cycle as result handoff. Throughput is one operation per (latency + 2) cycles minimum.
- precise_en toggling during CALC/DONE has no effect.
- Widths: no truncation other than defined above. Maximum legal quotient is all-ones with no overflow.

Test Plan:
- Precise:
  - Stimulus: dividend = 1000000, divisor = 300, precise_en = 1.
  - Required: quotient = 3333 (0x0D05), remainder = 100, flags 0, out_precise = 1, out_valid exactly 16 cycles after the accept edge.
- Approximate:
  - Stimulus: same operands, precise_en = 0.
  - Required: quotient = 0x0D00, remainder = 0, out_precise = 0, out_valid 8 cycles after accept.
- Divide by zero:
  - Stimulus: dividend = 0x12345678, divisor = 0.
  - Required: div_by_zero = 1, overflow = 0, quotient = 0xFFFF, remainder = 0, out_valid 1 cycle after accept.
- Overflow boundary:
  - Stimulus A: 0x00120000 / 0x0012 -> overflow = 1, quotient = 0xFFFF, 1-cycle latency.
  - Stimulus B: 0x0011FFFF / 0x0012 -> overflow = 0, quotient = 0xFFFF, remainder = 0x0011, 16-cycle latency.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles after out_valid while holding in_valid = 1 with new operands.
  - Required: outputs stable, in_ready = 0, no accept.
  - Then raise out_ready for 1 cycle: IDLE, and the new operands are accepted on the next cycle.
- Reset mid-operation:
  - Stimulus: pulse rst_n low during CALC iteration 7 of a precise op.
  - Required: out_valid = 0 and all outputs 0 immediately (asynchronously), in_ready = 1.
  - A subsequent 65535 / 1 precise op returns quotient = 0xFFFF, remainder = 0 with no residue from the aborted op.

Source files
------------

// File: rtl/approx_div_if.sv
// Handshake and operand/result bundle for the approximate restoring divider.
interface approx_div_if #(
    parameter int unsigned DW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              precise_en;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     quotient;
    logic [DW-1:0]     remainder;
    logic              div_by_zero;
    logic              overflow;
    logic              out_precise;

    modport master (
        output in_valid, dividend, divisor, precise_en, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, out_precise
    );

    modport slave (
        input  in_valid, dividend, divisor, precise_en, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, out_precise
    );
endinterface

// File: rtl/approx_div_32x16.sv
// Iterative restoring divider, 2*DW-bit dividend by DW-bit divisor. Precise mode runs DW
// steps; approximate mode runs APPROX_ITERS steps and zero-fills the low quotient bits.
module approx_div_32x16 #(
    parameter int unsigned DW           = 16,
    parameter int unsigned APPROX_ITERS = 8
) (
    input logic         clk,
    input logic         rst_n,
    approx_div_if.slave bus
);

    if (APPROX_ITERS == 0 || APPROX_ITERS > DW) begin : g_param_check
        $error("approx_div_32x16: APPROX_ITERS must be in 1..DW");
    end

    localparam int unsigned CW    = $clog2(DW + 1);
    localparam int unsigned SHIFT = DW - APPROX_ITERS;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d;     // partial remainder, always < divisor
    logic [DW-1:0]   lo_q, lo_d;       // dividend bits still to be shifted in, MSB first
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic            prec_q, prec_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   quotient_q, quotient_d;
    logic [DW-1:0]   remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic            out_prec_q, out_prec_d;

    logic [DW:0]     shifted;
    logic            ge;
    logic [DW-1:0]   rem_step;
    logic [DW-1:0]   quo_step;
    logic [DW-1:0]   quo_final;

    // One restoring step: shift in next dividend bit, trial-subtract, keep if non-negative.
    always_comb begin
        shifted   = {rem_q, lo_q[DW-1]};
        ge        = shifted >= {1'b0, dvs_q};
        rem_step  = ge ? DW'(shifted - {1'b0, dvs_q}) : shifted[DW-1:0];
        quo_step  = {quo_q[DW-2:0], ge};
        // Approximate runs produce only the top APPROX_ITERS bits; align them to the MSB.
        quo_final = prec_q ? quo_step : (quo_step << SHIFT);
    end

    // Next-state and result-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        prec_d      = prec_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        out_prec_d  = out_prec_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    dvs_d  = bus.divisor;
                    lo_d   = bus.dividend[DW-1:0];
                    // High half < divisor here, so the first DW steps of a full 2*DW-step
                    // division would yield zero quotient bits and leave exactly this remainder.
                    rem_d  = bus.dividend[2*DW-1:DW];
                    quo_d  = '0;
                    prec_d = bus.precise_en;
                    cnt_d  = bus.precise_en ? CW'(DW) : CW'(APPROX_ITERS);
                    if (bus.divisor == '0 || bus.dividend[2*DW-1:DW] >= bus.divisor) begin
                        // out_valid rises on the following edge while in StDone.
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = (bus.divisor == '0);
                        ovf_d       = (bus.divisor != '0);
                        out_prec_d  = bus.precise_en;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = rem_step;
                quo_d = quo_step;
                lo_d  = {lo_q[DW-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    quotient_d  = quo_final;
                    remainder_d = (prec_q || APPROX_ITERS == DW) ? rem_step : '0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    out_prec_d  = prec_q;
                end
            end
            StDone: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            prec_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_prec_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            prec_q      <= prec_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            out_prec_q  <= out_prec_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign bus.out_precise = out_prec_q;

endmodule

// File: tb/tb_approx_div_32x16.sv
// Scoreboard bench for approx_div_32x16: expectations pushed at accept, checked at result.
module tb_approx_div_32x16;

    localparam int unsigned DW = 16;
    localparam int unsigned AI = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    approx_div_if #(.DW(DW)) dif ();

    approx_div_32x16 #(
        .DW          (DW),
        .APPROX_ITERS(AI)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        logic        prec;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, then mode-dependent truncation.
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input logic p);
        exp_t        e;
        logic [31:0] q32;
        logic [15:0] mask;
        e.prec = p;
        e.dbz  = 1'b0;
        e.ovf  = 1'b0;
        if (b == 16'd0) begin
            e.dbz = 1'b1; e.q = 16'hFFFF; e.r = 16'd0; e.lat = 1;
        end else if (a[31:16] >= b) begin
            e.ovf = 1'b1; e.q = 16'hFFFF; e.r = 16'd0; e.lat = 1;
        end else begin
            q32  = a / {16'd0, b};
            e.q  = q32[15:0];
            e.r  = 16'(a % {16'd0, b});
            e.lat = p ? int'(DW) : int'(AI);
            if (!p) begin
                mask = 16'hFFFF << (DW - AI);
                e.q  = e.q & mask;
                e.r  = 16'd0;
            end
        end
        return e;
    endfunction

    // Present operands, wait for in_ready, push expectation at the accept edge.
    task automatic launch(input logic [31:0] a, input logic [15:0] b, input logic p);
        int k = 0;
        @(negedge clk);
        dif.dividend   = a;
        dif.divisor    = b;
        dif.precise_en = p;
        dif.in_valid   = 1'b1;
        while (!dif.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!dif.in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            dif.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(model(a, b, p));
        #1;
        dif.in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to out_valid, then pop and compare.
    task automatic collect(input string tag);
        int   cyc = 0;
        exp_t e;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!dif.out_valid && cyc < 40);
        if (!dif.out_valid) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".q"},    dif.quotient,    e.q);
        chk({tag, ".r"},    dif.remainder,   e.r);
        chk({tag, ".dbz"},  dif.div_by_zero, e.dbz);
        chk({tag, ".ovf"},  dif.overflow,    e.ovf);
        chk({tag, ".prec"}, dif.out_precise, e.prec);
        chk({tag, ".lat"},  cyc,             e.lat);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input logic p);
        dif.out_ready = 1'b1;
        launch(a, b, p);
        collect(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] rb, rh;
        dif.in_valid   = 1'b0;
        dif.dividend   = '0;
        dif.divisor    = '0;
        dif.precise_en = 1'b0;
        dif.out_ready  = 1'b1;

        #12;
        chk("rst.in_ready",  dif.in_ready,    1);
        chk("rst.out_valid", dif.out_valid,   0);
        chk("rst.q",         dif.quotient,    0);
        chk("rst.r",         dif.remainder,   0);
        chk("rst.flags",     {dif.div_by_zero, dif.overflow, dif.out_precise}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("precise", 32'd1000000, 16'd300, 1'b1);
        chk("precise.q_lit", dif.quotient,  16'h0D05);
        chk("precise.r_lit", dif.remainder, 16'd100);

        run_op("approx", 32'd1000000, 16'd300, 1'b0);
        chk("approx.q_lit", dif.quotient, 16'h0D00);

        run_op("dbz", 32'h12345678, 16'd0, 1'b1);
        chk("dbz.flag_lit", dif.div_by_zero, 1);

        run_op("ovf_a", 32'h00120000, 16'h0012, 1'b1);
        chk("ovf_a.flag_lit", dif.overflow, 1);

        run_op("ovf_b", 32'h0011FFFF, 16'h0012, 1'b1);
        chk("ovf_b.q_lit", dif.quotient,  16'hFFFF);
        chk("ovf_b.r_lit", dif.remainder, 16'h0011);

        for (int i = 0; i < 10; i++) begin
            rb = 16'($urandom_range(1, 65535));
            rh = 16'($urandom_range(0, int'(rb) - 1));
            run_op("rand", {rh, 16'($urandom)}, rb, 1'($urandom_range(0, 1)));
        end

        // Backpressure: result held, new operands waiting but not taken.
        dif.out_ready = 1'b0;
        launch(32'd1000000, 16'd300, 1'b1);
        collect("bp");
        dif.dividend   = 32'd5000;
        dif.divisor    = 16'd7;
        dif.precise_en = 1'b1;
        dif.in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.in_ready",  dif.in_ready,  0);
            chk("bp.out_valid", dif.out_valid, 1);
            chk("bp.q_hold",    dif.quotient,  16'h0D05);
        end
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.release_valid", dif.out_valid, 0);
        chk("bp.release_ready", dif.in_ready,  1);
        @(posedge clk);
        sb.push_back(model(32'd5000, 16'd7, 1'b1));
        #1;
        chk("bp.accepted", dif.in_ready, 0);
        dif.in_valid = 1'b0;
        collect("bp_next");
        @(posedge clk);
        #1;

        // Reset during the 7th CALC iteration of a precise op.
        launch(32'h12345678, 16'h5678, 1'b1);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", dif.out_valid, 0);
        chk("mid_rst.in_ready",  dif.in_ready,  1);
        chk("mid_rst.q",         dif.quotient,  0);
        chk("mid_rst.r",         dif.remainder, 0);
        chk("mid_rst.flags",     {dif.div_by_zero, dif.overflow, dif.out_precise}, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        run_op("post_rst", 32'd65535, 16'd1, 1'b1);
        chk("post_rst.q_lit", dif.quotient,  16'hFFFF);
        chk("post_rst.r_lit", dif.remainder, 16'd0);

        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
